// File: rtl/tap_result_drain_if.sv
// Result-side bundle between the search core, the drain block and the host byte stream.
// master = searcher/sink side, slave = tap_result_drain.
interface tap_result_drain_if #(
  parameter int NUM_OF_TAPS = 6
);
  logic                     found;
  logic [NUM_OF_TAPS*8-1:0] co_buf;
  logic                     ext_res;
  logic [7:0]               dout;
  logic                     dout_valid;
  logic                     dout_ready;
  logic                     fifo_full;
  logic                     stalled;
  logic [15:0]              result_cnt;

  modport master (
    output found, co_buf, dout_ready,
    input  ext_res, dout, dout_valid, fifo_full, stalled, result_cnt
  );

  modport slave (
    input  found, co_buf, dout_ready,
    output ext_res, dout, dout_valid, fifo_full, stalled, result_cnt
  );
endinterface

// File: rtl/tap_result_drain.sv
// Captures searcher tap sets into a small FIFO, restarts the searcher with ext_res, and
// drains each entry as a header-prefixed byte frame over a valid/ready stream.
module tap_result_drain #(
  parameter int          NUM_OF_TAPS = 6,
  parameter int          DEPTH       = 4,
  parameter logic [7:0]  HDR         = 8'hA5
) (
  input  logic                  clk,
  input  logic                  res,
  tap_result_drain_if.slave     bus
);

  localparam int ENTRY_W = NUM_OF_TAPS * 8;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int IDX_W   = (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;

  typedef enum logic {C_IDLE, C_HOLD} cap_state_t;
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_TAP} ser_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full, empty;
  logic               push, pop;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Capture side
  cap_state_t  cap_state, cap_next;
  logic        ext_res_p1;
  logic        stalled_p1;
  logic [15:0] result_cnt_p1;

  // Serializer side
  ser_state_t         ser_state, ser_next;
  logic [ENTRY_W-1:0] shift_p0, shift_nxt;
  logic [IDX_W-1:0]   idx_p0, idx_nxt;
  logic [7:0]         dout_p1, dout_nxt;
  logic               vld_p1, vld_nxt;

  // Push is gated on the registered count only, so a pop in the same cycle never makes room.
  always_comb begin
    cap_next = cap_state;
    push     = 1'b0;
    case (cap_state)
      C_IDLE: begin
        if (bus.found && !full) begin
          push     = 1'b1;
          cap_next = C_HOLD;
        end
      end
      C_HOLD: begin
        if (!bus.found) cap_next = C_IDLE;
      end
      default: cap_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cap_state     <= C_IDLE;
      ext_res_p1    <= 1'b0;
      stalled_p1    <= 1'b0;
      result_cnt_p1 <= '0;
    end else begin
      cap_state  <= cap_next;
      ext_res_p1 <= push;
      stalled_p1 <= bus.found && full && (cap_state == C_IDLE);
      if (push) result_cnt_p1 <= sat_inc(result_cnt_p1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.co_buf;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The head entry stays in the FIFO until its last tap byte is accepted.
  always_comb begin
    ser_next  = ser_state;
    shift_nxt = shift_p0;
    idx_nxt   = idx_p0;
    dout_nxt  = dout_p1;
    vld_nxt   = vld_p1;
    pop       = 1'b0;
    case (ser_state)
      S_IDLE: begin
        if (!empty) begin
          shift_nxt = mem[rd_ptr];
          dout_nxt  = HDR;
          vld_nxt   = 1'b1;
          ser_next  = S_HDR;
        end
      end
      S_HDR: begin
        if (vld_p1 && bus.dout_ready) begin
          dout_nxt  = shift_p0[ENTRY_W-1 -: 8];
          shift_nxt = shift_p0 << 8;
          idx_nxt   = '0;
          ser_next  = S_TAP;
        end
      end
      S_TAP: begin
        if (vld_p1 && bus.dout_ready) begin
          if (idx_p0 == IDX_W'(NUM_OF_TAPS - 1)) begin
            pop      = 1'b1;
            dout_nxt = 8'h00;
            vld_nxt  = 1'b0;
            ser_next = S_IDLE;
          end else begin
            idx_nxt   = idx_p0 + IDX_W'(1);
            dout_nxt  = shift_p0[ENTRY_W-1 -: 8];
            shift_nxt = shift_p0 << 8;
          end
        end
      end
      default: ser_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      ser_state <= S_IDLE;
      idx_p0    <= '0;
      dout_p1   <= 8'h00;
      vld_p1    <= 1'b0;
    end else begin
      ser_state <= ser_next;
      idx_p0    <= idx_nxt;
      dout_p1   <= dout_nxt;
      vld_p1    <= vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift_p0 <= shift_nxt;
  end

  assign bus.ext_res    = ext_res_p1;
  assign bus.stalled    = stalled_p1;
  assign bus.result_cnt = result_cnt_p1;
  assign bus.fifo_full  = full;
  assign bus.dout       = dout_p1;
  assign bus.dout_valid = vld_p1;

endmodule
